// File: rtl/tpfifo_sched_if.sv
// Handshake/bus bundle between the matmul control and the transpose-FIFO sequencer.
// master = control side (drives start/stall/abort), slave = sequencer.
interface tpfifo_sched_if #(
  parameter int DEPTH = 8
);
  logic             start;
  logic             stall;
  logic             abort;
  logic [DEPTH-1:0] wren;
  logic [DEPTH-1:0] en;
  logic [DEPTH-1:0] valid;
  logic             busy;
  logic             done;
  logic [31:0]      stall_cycles;

  modport master (
    output start, stall, abort,
    input  wren, en, valid, busy, done, stall_cycles
  );

  modport slave (
    input  start, stall, abort,
    output wren, en, valid, busy, done, stall_cycles
  );
endinterface

// File: rtl/tpfifo_sched.sv
// Transpose-FIFO bank sequencer: one-cycle parallel load, diagonally skewed shift enables, drain wait, done pulse.
// Optional stall counter built only when TPFIFO_SCHED_PERF_EN is defined.
module tpfifo_sched #(
  parameter int DEPTH     = 8,
  parameter int DRAIN_CYC = 16
) (
  input logic           clk,
  input logic           rst_n,
  tpfifo_sched_if.slave bus
);
  localparam int TW = $clog2(2 * DEPTH);
  localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(2 * DEPTH - 2);
  localparam logic [DW-1:0] D_LAST = DW'((DRAIN_CYC > 0) ? DRAIN_CYC - 1 : 0);

  typedef enum logic [2:0] {IDLE, LOAD, FEED, DRAIN, DONE} state_t;

  state_t           state;
  logic [TW-1:0]    t;
  logic [DW-1:0]    dcnt;
  logic [DEPTH-1:0] wren_q;
  logic [DEPTH-1:0] win_q;
  logic             busy_q;
  logic             done_q;

  // FIFO i is live on feed steps i .. i+DEPTH-1.
  function automatic logic [DEPTH-1:0] window(input logic [TW-1:0] step);
    logic [DEPTH-1:0] w;
    w = '0;
    for (int i = 0; i < DEPTH; i++)
      w[i] = (int'(step) >= i) && (int'(step) < i + DEPTH);
    return w;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      t      <= '0;
      dcnt   <= '0;
      wren_q <= '0;
      win_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      wren_q <= '0;
      done_q <= 1'b0;
      if (state != IDLE && bus.abort) begin
        state  <= IDLE;
        win_q  <= '0;
        busy_q <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start) begin
              state  <= LOAD;
              wren_q <= '1;
              busy_q <= 1'b1;
            end
          end
          LOAD: begin
            state <= FEED;
            t     <= '0;
            win_q <= window('0);
          end
          FEED: begin
            if (!bus.stall) begin
              if (t == T_LAST) begin
                win_q <= '0;
                if (DRAIN_CYC == 0) begin
                  state  <= DONE;
                  done_q <= 1'b1;
                end else begin
                  state <= DRAIN;
                  dcnt  <= '0;
                end
              end else begin
                t     <= t + 1'b1;
                win_q <= window(t + 1'b1);
              end
            end
          end
          DRAIN: begin
            if (!bus.stall) begin
              if (dcnt == D_LAST) begin
                state  <= DONE;
                done_q <= 1'b1;
              end else begin
                dcnt <= dcnt + 1'b1;
              end
            end
          end
          DONE: begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Shift enables drop in the very cycle stall is raised so the bank never advances on a frozen step.
  assign bus.wren  = wren_q;
  assign bus.en    = win_q & {DEPTH{~bus.stall}};
  assign bus.valid = win_q & {DEPTH{~bus.stall}};
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

`ifdef TPFIFO_SCHED_PERF_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (state == IDLE && bus.start) begin
      stall_cnt <= '0;
    end else if (bus.stall && (state == FEED || state == DRAIN) && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign bus.stall_cycles = stall_cnt;
`else
  assign bus.stall_cycles = '0;
`endif

endmodule

// File: tb/tb_tpfifo_sched.sv
// Scoreboard bench: two sequencers (drain 16 and drain 0) run the same stimulus against a progress-index model.
module tb_tpfifo_sched;
  localparam int D = 8;
`ifdef TPFIFO_SCHED_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct packed {
    logic [D-1:0] wren;
    logic [D-1:0] en;
    logic [D-1:0] valid;
    logic         busy;
    logic         done;
    logic [31:0]  sc;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tpfifo_sched_if #(.DEPTH(D)) sif0 ();
  tpfifo_sched_if #(.DEPTH(D)) sif1 ();

  tpfifo_sched #(.DEPTH(D), .DRAIN_CYC(16)) u0 (.clk(clk), .rst_n(rst_n), .bus(sif0));
  tpfifo_sched #(.DEPTH(D), .DRAIN_CYC(0))  u1 (.clk(clk), .rst_n(rst_n), .bus(sif1));

  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  string tname = "";
  obs_t  exp_q[$];
  int    done0[$];
  int    done1[$];

  bit m_act[2];
  int m_e[2];
  int m_sc[2];

  function automatic int dr(input int k);
    return (k == 0) ? 16 : 0;
  endfunction

  // Progress index e: 1 = load, 2..2D = feed step e-2, then drain, then done.
  function automatic obs_t model_out(input int k, input bit sl);
    obs_t o;
    int   e;
    int   t;
    o = '0;
    e = m_e[k];
    if (m_act[k]) begin
      o.busy = 1'b1;
      if (e == 1) o.wren = '1;
      if (e >= 2 && e <= 2 * D) begin
        t = e - 2;
        for (int i = 0; i < D; i++)
          if (i <= t && t < i + D && !sl) begin
            o.en[i]    = 1'b1;
            o.valid[i] = 1'b1;
          end
      end
      if (e == 2 * D + dr(k) + 1) o.done = 1'b1;
    end
    o.sc = PERF ? 32'(m_sc[k]) : 32'd0;
    return o;
  endfunction

  task automatic model_step(input int k, input bit st, input bit sl, input bit ab);
    bit fd;
    if (!m_act[k]) begin
      if (st) begin
        m_act[k] = 1'b1;
        m_e[k]   = 1;
        m_sc[k]  = 0;
      end
    end else begin
      fd = (m_e[k] >= 2) && (m_e[k] <= 2 * D + dr(k));
      if (sl && fd) m_sc[k]++;
      if (ab) m_act[k] = 1'b0;
      else if (m_e[k] == 2 * D + dr(k) + 1) m_act[k] = 1'b0;
      else if (!(sl && fd)) m_e[k]++;
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_act[k] = 1'b0;
      m_e[k]   = 0;
      m_sc[k]  = 0;
    end
  endtask

  // One clock cycle: entered and left at the falling edge.
  task automatic tick(input bit st, input bit sl, input bit ab);
    obs_t e;
    obs_t g;
    sif0.start = st; sif0.stall = sl; sif0.abort = ab;
    sif1.start = st; sif1.stall = sl; sif1.abort = ab;
    #1;
    for (int k = 0; k < 2; k++) exp_q.push_back(model_out(k, sl));
    for (int k = 0; k < 2; k++) begin
      e = exp_q.pop_front();
      if (k == 0) g = {sif0.wren, sif0.en, sif0.valid, sif0.busy, sif0.done, sif0.stall_cycles};
      else        g = {sif1.wren, sif1.en, sif1.valid, sif1.busy, sif1.done, sif1.stall_cycles};
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL %s dut%0d cycle %0d: got wren=%h en=%h valid=%h busy=%b done=%b sc=%0d, expected wren=%h en=%h valid=%h busy=%b done=%b sc=%0d",
                 tname, k, cyc, g.wren, g.en, g.valid, g.busy, g.done, g.sc,
                 e.wren, e.en, e.valid, e.busy, e.done, e.sc);
      end
      if (g.done === 1'b1) begin
        if (k == 0) done0.push_back(cyc);
        else        done1.push_back(cyc);
      end
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_step(k, st, sl, ab);
    cyc++;
    @(negedge clk);
  endtask

  task automatic begin_test(input string n);
    tname = n;
    cyc   = 0;
    done0.delete();
    done1.delete();
  endtask

  task automatic test_reset();
    obs_t g;
    tname = "reset";
    sif0.start = 0; sif0.stall = 0; sif0.abort = 0;
    sif1.start = 0; sif1.stall = 0; sif1.abort = 0;
    model_reset();
    #2;
    g = {sif0.wren, sif0.en, sif0.valid, sif0.busy, sif0.done, sif0.stall_cycles};
    checks++;
    if (g !== '0) begin errors++; $display("FAIL reset dut0: got %h expected 0", g); end
    g = {sif1.wren, sif1.en, sif1.valid, sif1.busy, sif1.done, sif1.stall_cycles};
    checks++;
    if (g !== '0) begin errors++; $display("FAIL reset dut1: got %h expected 0", g); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick(0, 0, 0);
  endtask

  task automatic test_basic();
    begin_test("basic");
    tick(1, 0, 0);
    repeat (38) tick(0, 0, 0);
    checks++;
    if (done0.size() != 1 || done0[0] != 33) begin
      errors++; $display("FAIL basic_done dut0: got %0d pulses first at %0d, expected 1 at 33", done0.size(), (done0.size() > 0) ? done0[0] : -1);
    end
    checks++;
    if (done1.size() != 1 || done1[0] != 17) begin
      errors++; $display("FAIL basic_done dut1: got %0d pulses first at %0d, expected 1 at 17", done1.size(), (done1.size() > 0) ? done1[0] : -1);
    end
  endtask

  task automatic test_stall();
    begin_test("stall");
    tick(1, 0, 0);
    for (int c = 1; c < 42; c++) tick(0, (c >= 5 && c <= 7), 0);
    checks++;
    if (done0.size() != 1 || done0[0] != 36) begin
      errors++; $display("FAIL stall_done dut0: got %0d pulses first at %0d, expected 1 at 36", done0.size(), (done0.size() > 0) ? done0[0] : -1);
    end
    checks++;
    if (done1.size() != 1 || done1[0] != 20) begin
      errors++; $display("FAIL stall_done dut1: got %0d pulses first at %0d, expected 1 at 20", done1.size(), (done1.size() > 0) ? done1[0] : -1);
    end
  endtask

  task automatic test_abort();
    begin_test("abort");
    tick(1, 0, 0);
    for (int c = 1; c < 10; c++) tick(0, 0, 0);
    tick(0, 0, 1);
    tick(1, 0, 0);
    for (int c = 12; c < 50; c++) tick(0, 0, 0);
    checks++;
    if (done0.size() != 1 || done0[0] != 44) begin
      errors++; $display("FAIL abort_done dut0: got %0d pulses first at %0d, expected 1 at 44", done0.size(), (done0.size() > 0) ? done0[0] : -1);
    end
    checks++;
    if (done1.size() != 1 || done1[0] != 28) begin
      errors++; $display("FAIL abort_done dut1: got %0d pulses first at %0d, expected 1 at 28", done1.size(), (done1.size() > 0) ? done1[0] : -1);
    end
  endtask

  task automatic test_back_to_back();
    begin_test("back_to_back");
    for (int c = 0; c < 68; c++) tick(1, 0, 0);
    for (int c = 68; c < 76; c++) tick(0, 0, 0);
    checks++;
    if (done0.size() != 2 || done0[0] != 33 || done0[1] != 67) begin
      errors++; $display("FAIL b2b_done dut0: got %0d pulses, expected 2 at 33 and 67", done0.size());
    end
    checks++;
    if (done1.size() != 4 || done1[0] != 17 || done1[1] != 35 || done1[3] != 71) begin
      errors++; $display("FAIL b2b_done dut1: got %0d pulses, expected 4 at 17,35,53,71", done1.size());
    end
  endtask

  task automatic test_async_reset();
    obs_t g;
    begin_test("async_reset");
    tick(1, 0, 0);
    for (int c = 1; c < 20; c++) tick(0, (c == 18), 0);
    sif0.start = 0; sif0.stall = 0; sif0.abort = 0;
    sif1.start = 0; sif1.stall = 0; sif1.abort = 0;
    rst_n = 1'b0;
    #1;
    g = {sif0.wren, sif0.en, sif0.valid, sif0.busy, sif0.done, sif0.stall_cycles};
    checks++;
    if (g !== '0) begin errors++; $display("FAIL async_reset dut0: got %h expected 0", g); end
    g = {sif1.wren, sif1.en, sif1.valid, sif1.busy, sif1.done, sif1.stall_cycles};
    checks++;
    if (g !== '0) begin errors++; $display("FAIL async_reset dut1: got %h expected 0", g); end
    model_reset();
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    repeat (5) tick(0, 0, 0);
    begin_test("post_reset");
    tick(1, 0, 0);
    repeat (35) tick(0, 0, 0);
    checks++;
    if (done0.size() != 1 || done0[0] != 33) begin
      errors++; $display("FAIL post_reset_done dut0: got %0d pulses first at %0d, expected 1 at 33", done0.size(), (done0.size() > 0) ? done0[0] : -1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_abort();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
